// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite encodings shared by the SDRAM bus blocks.
package ahb_lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/ahb_lite_dual_master_arbiter.sv
// ahb_lite_dual_master_arbiter: shares one AHB-Lite slave between two masters, stalling the loser via HREADY.
module ahb_lite_dual_master_arbiter
    import ahb_lite_pkg::*;
#(
    parameter bit DEFAULT_MASTER = 1'b0,
    parameter int CNT_BITS       = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [31:0]         M0_HADDR,
    input  logic [2:0]          M0_HBURST,
    input  logic                M0_HSEL,
    input  logic [2:0]          M0_HSIZE,
    input  logic [1:0]          M0_HTRANS,
    input  logic [31:0]         M0_HWDATA,
    input  logic                M0_HWRITE,
    output logic [31:0]         M0_HRDATA,
    output logic                M0_HREADY,
    output logic                M0_HRESP,
    input  logic [31:0]         M1_HADDR,
    input  logic [2:0]          M1_HBURST,
    input  logic                M1_HSEL,
    input  logic [2:0]          M1_HSIZE,
    input  logic [1:0]          M1_HTRANS,
    input  logic [31:0]         M1_HWDATA,
    input  logic                M1_HWRITE,
    output logic [31:0]         M1_HRDATA,
    output logic                M1_HREADY,
    output logic                M1_HRESP,
    output logic [31:0]         S_HADDR,
    output logic [2:0]          S_HBURST,
    output logic                S_HSEL,
    output logic [2:0]          S_HSIZE,
    output logic [1:0]          S_HTRANS,
    output logic                S_HWRITE,
    output logic [31:0]         S_HWDATA,
    input  logic [31:0]         S_HRDATA,
    input  logic                S_HREADY,
    input  logic                S_HRESP,
    output logic                HMASTER,
    output logic [CNT_BITS-1:0] M0_XFERCNT,
    output logic [CNT_BITS-1:0] M1_XFERCNT
);
    logic                owner_q, owner_d, downer_q, downer_d;
    logic [CNT_BITS-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                req0, req1, req_own, req_oth;

    assign req0    = M0_HSEL & M0_HTRANS[1];
    assign req1    = M1_HSEL & M1_HTRANS[1];
    assign req_own = owner_q ? req1 : req0;
    assign req_oth = owner_q ? req0 : req1;

    // Ownership moves only when the owner's IDLE is accepted, so its next data phase is empty.
    always_comb begin
        owner_d  = owner_q;
        downer_d = downer_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        if (S_HREADY) begin
            downer_d = owner_q;
            if (req_own) begin
                cnt0_d = owner_q ? cnt0_q : cnt0_q + CNT_BITS'(1);
                cnt1_d = owner_q ? cnt1_q + CNT_BITS'(1) : cnt1_q;
            end else if (req_oth) begin
                owner_d = ~owner_q;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner_q  <= DEFAULT_MASTER;
            downer_q <= DEFAULT_MASTER;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            owner_q  <= owner_d;
            downer_q <= downer_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign S_HADDR    = owner_q ? M1_HADDR  : M0_HADDR;
    assign S_HBURST   = owner_q ? M1_HBURST : M0_HBURST;
    assign S_HSEL     = owner_q ? M1_HSEL   : M0_HSEL;
    assign S_HSIZE    = owner_q ? M1_HSIZE  : M0_HSIZE;
    assign S_HTRANS   = owner_q ? M1_HTRANS : M0_HTRANS;
    assign S_HWRITE   = owner_q ? M1_HWRITE : M0_HWRITE;
    assign S_HWDATA   = downer_q ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA  = S_HRDATA;
    assign M1_HRDATA  = S_HRDATA;
    assign M0_HREADY  = owner_q ? 1'b0 : S_HREADY;
    assign M1_HREADY  = owner_q ? S_HREADY : 1'b0;
    assign M0_HRESP   = downer_q ? HRESP_OKAY : S_HRESP;
    assign M1_HRESP   = downer_q ? S_HRESP : HRESP_OKAY;
    assign HMASTER    = owner_q;
    assign M0_XFERCNT = cnt0_q;
    assign M1_XFERCNT = cnt1_q;
endmodule

// File: tb/tb_ahb_lite_dual_master_arbiter.sv
// tb_ahb_lite_dual_master_arbiter: directed scenarios plus randomized traffic against a cycle-level ownership model.
module tb_ahb_lite_dual_master_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] haddr[2], hwdata[2], m_hrdata[2], xfercnt[2];
    logic [2:0]  hburst[2], hsize[2];
    logic [1:0]  htrans[2];
    logic        hsel[2], hwrite[2], m_hready[2], m_hresp[2];
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [2:0]  s_hburst, s_hsize;
    logic [1:0]  s_htrans;
    logic        s_hsel, s_hwrite, s_hready, s_hresp, hmaster;
    int          checks = 0, failures = 0;
    int          own, down;
    int unsigned cnt[2];

    always #5 clk = ~clk;

    ahb_lite_dual_master_arbiter #(.DEFAULT_MASTER(1'b0), .CNT_BITS(32)) dut (
        .HCLK(clk), .HRESETn(rstn),
        .M0_HADDR(haddr[0]), .M0_HBURST(hburst[0]), .M0_HSEL(hsel[0]), .M0_HSIZE(hsize[0]),
        .M0_HTRANS(htrans[0]), .M0_HWDATA(hwdata[0]), .M0_HWRITE(hwrite[0]),
        .M0_HRDATA(m_hrdata[0]), .M0_HREADY(m_hready[0]), .M0_HRESP(m_hresp[0]),
        .M1_HADDR(haddr[1]), .M1_HBURST(hburst[1]), .M1_HSEL(hsel[1]), .M1_HSIZE(hsize[1]),
        .M1_HTRANS(htrans[1]), .M1_HWDATA(hwdata[1]), .M1_HWRITE(hwrite[1]),
        .M1_HRDATA(m_hrdata[1]), .M1_HREADY(m_hready[1]), .M1_HRESP(m_hresp[1]),
        .S_HADDR(s_haddr), .S_HBURST(s_hburst), .S_HSEL(s_hsel), .S_HSIZE(s_hsize),
        .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite), .S_HWDATA(s_hwdata),
        .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
        .HMASTER(hmaster), .M0_XFERCNT(xfercnt[0]), .M1_XFERCNT(xfercnt[1])
    );

    function automatic bit req(int m);
        return hsel[m] & htrans[m][1];
    endfunction

    // Reference: arbitration rules applied once per rising edge using the inputs seen at that edge.
    task automatic tick();
        int nxt;
        @(posedge clk);
        if (!rstn) begin
            own = 0; down = 0; cnt[0] = 0; cnt[1] = 0;
        end else if (s_hready) begin
            nxt = own;
            if (req(own)) cnt[own]++;
            else if (req(1 - own)) nxt = 1 - own;
            down = own;
            own = nxt;
        end
        #1;
    endtask

    task automatic set_m(int m, bit sel, logic [1:0] tr, logic [31:0] a, bit wr, logic [31:0] wd);
        hsel[m] = sel; htrans[m] = tr; haddr[m] = a; hwrite[m] = wr; hwdata[m] = wd;
        hburst[m] = 3'b000; hsize[m] = 3'b010;
    endtask

    task automatic do_reset();
        set_m(0, 0, 2'b00, 0, 0, 0);
        set_m(1, 0, 2'b00, 0, 0, 0);
        s_hready = 1; s_hresp = 0; s_hrdata = 0; rstn = 0;
        tick(); tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (hmaster !== 1'b0) begin failures++; $display("FAIL reset_hmaster got=%0h exp=0", hmaster); end
        checks++; if (xfercnt[0] !== 0 || xfercnt[1] !== 0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", xfercnt[0], xfercnt[1]); end
        checks++; if (m_hready[0] !== 1'b1 || m_hready[1] !== 1'b0) begin failures++; $display("FAIL reset_hready got=%0b%0b exp=10", m_hready[0], m_hready[1]); end
    endtask

    task automatic test_handover();
        do_reset();
        set_m(1, 1, 2'b10, 32'h100, 1, 0);
        #1;
        checks++; if (m_hready[1] !== 1'b0) begin failures++; $display("FAIL ho_m1_stall got=%0b exp=0", m_hready[1]); end
        tick();
        checks++; if (hmaster !== 1'b1 || s_haddr !== 32'h100 || s_hwrite !== 1'b1) begin failures++; $display("FAIL ho_grant got=%0b/%0h exp=1/100", hmaster, s_haddr); end
        checks++; if (m_hready[1] !== 1'b1) begin failures++; $display("FAIL ho_m1_ready got=%0b exp=1", m_hready[1]); end
        tick();
        set_m(1, 0, 2'b00, 0, 0, 32'hA5A5_0001);
        #1;
        checks++; if (xfercnt[1] !== 1) begin failures++; $display("FAIL ho_cnt got=%0d exp=1", xfercnt[1]); end
        checks++; if (s_hwdata !== 32'hA5A5_0001) begin failures++; $display("FAIL ho_wdata got=%0h exp=a5a50001", s_hwdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_m(1, 1, 2'b10, 32'h200, 0, 0);
        for (int i = 0; i < 8; i++) begin
            set_m(0, 1, i == 0 ? 2'b10 : 2'b11, 32'(4 * i), 0, 0);
            #1;
            checks++; if (hmaster !== 1'b0 || m_hready[1] !== 1'b0 || s_haddr !== 32'(4 * i)) begin failures++; $display("FAIL b2b_beat%0d got=%0b/%0b/%0h exp=0/0/%0h", i, hmaster, m_hready[1], s_haddr, 4 * i); end
            tick();
        end
        set_m(0, 0, 2'b00, 0, 0, 0);
        tick();
        checks++; if (hmaster !== 1'b1 || s_haddr !== 32'h200) begin failures++; $display("FAIL b2b_handover got=%0b/%0h exp=1/200", hmaster, s_haddr); end
        checks++; if (xfercnt[0] !== 8) begin failures++; $display("FAIL b2b_cnt got=%0d exp=8", xfercnt[0]); end
    endtask

    task automatic test_wait_states();
        do_reset();
        set_m(0, 1, 2'b10, 32'h40, 1, 0);
        set_m(1, 1, 2'b10, 32'h300, 1, 32'h1111_2222);
        tick();
        set_m(0, 0, 2'b00, 0, 0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            s_hready = 0;
            #1;
            checks++; if (hmaster !== 1'b0 || s_hwdata !== 32'hDEAD_BEEF || m_hready[0] !== 1'b0 || m_hready[1] !== 1'b0) begin failures++; $display("FAIL ws_hold%0d got=%0b/%0h exp=0/deadbeef", i, hmaster, s_hwdata); end
            tick();
        end
        s_hready = 1;
        #1;
        checks++; if (s_hwdata !== 32'hDEAD_BEEF || m_hready[0] !== 1'b1) begin failures++; $display("FAIL ws_release got=%0h exp=deadbeef", s_hwdata); end
        tick();
        checks++; if (hmaster !== 1'b1 || s_hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ws_handover got=%0b/%0h exp=1/deadbeef", hmaster, s_hwdata); end
        tick();
        set_m(1, 0, 2'b00, 0, 0, 32'h1111_2222);
        #1;
        checks++; if (s_hwdata !== 32'h1111_2222) begin failures++; $display("FAIL ws_m1_wdata got=%0h exp=11112222", s_hwdata); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        set_m(0, 1, 2'b10, 32'h10, 0, 0);
        set_m(1, 1, 2'b10, 32'h20, 0, 0);
        #1;
        checks++; if (hmaster !== 1'b0 || m_hready[1] !== 1'b0) begin failures++; $display("FAIL sim_first got=%0b/%0b exp=0/0", hmaster, m_hready[1]); end
        tick();
        checks++; if (hmaster !== 1'b0) begin failures++; $display("FAIL sim_stay got=%0b exp=0", hmaster); end
        set_m(0, 0, 2'b00, 0, 0, 0);
        tick();
        checks++; if (hmaster !== 1'b1 || s_haddr !== 32'h20) begin failures++; $display("FAIL sim_grant got=%0b/%0h exp=1/20", hmaster, s_haddr); end
    endtask

    task automatic test_error();
        do_reset();
        set_m(1, 1, 2'b10, 32'h500, 0, 0);
        tick(); tick();
        set_m(1, 0, 2'b00, 0, 0, 0);
        set_m(0, 1, 2'b10, 32'h600, 0, 0);
        s_hready = 0; s_hresp = 1;
        #1;
        checks++; if (m_hresp[1] !== 1'b1 || m_hresp[0] !== 1'b0 || m_hready[1] !== 1'b0) begin failures++; $display("FAIL err_cyc1 got=%0b%0b%0b exp=100", m_hresp[1], m_hresp[0], m_hready[1]); end
        tick();
        s_hready = 1;
        #1;
        checks++; if (m_hresp[1] !== 1'b1 || m_hresp[0] !== 1'b0 || m_hready[1] !== 1'b1 || hmaster !== 1'b1) begin failures++; $display("FAIL err_cyc2 got=%0b%0b%0b%0b exp=1011", m_hresp[1], m_hresp[0], m_hready[1], hmaster); end
        tick();
        s_hresp = 0;
        #1;
        checks++; if (hmaster !== 1'b0) begin failures++; $display("FAIL err_after got=%0b exp=0", hmaster); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(1, 1, 2'b10, 32'h700, 1, 0);
        tick(); tick();
        s_hready = 0; rstn = 0;
        tick();
        rstn = 1; s_hready = 1;
        set_m(1, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (hmaster !== 1'b0 || xfercnt[0] !== 0 || xfercnt[1] !== 0) begin failures++; $display("FAIL rst_mid got=%0b/%0d/%0d exp=0/0/0", hmaster, xfercnt[0], xfercnt[1]); end
        set_m(0, 1, 2'b10, 32'h800, 0, 0);
        tick();
        set_m(0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (xfercnt[0] !== 1) begin failures++; $display("FAIL rst_next got=%0d exp=1", xfercnt[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++)
                set_m(m, 1'($urandom), 2'($urandom), $urandom, 1'($urandom), $urandom);
            s_hready = ($urandom_range(0, 3) != 0);
            s_hresp = 1'($urandom);
            s_hrdata = $urandom;
            rstn = ($urandom_range(0, 31) != 0);
            #1;
            checks++; if (hmaster !== 1'(own) || s_haddr !== haddr[own] || s_htrans !== htrans[own] || s_hsel !== hsel[own]) begin failures++; $display("FAIL rnd_addr n=%0d got=%0b/%0h exp=%0d/%0h", n, hmaster, s_haddr, own, haddr[own]); end
            checks++; if (s_hwdata !== hwdata[down]) begin failures++; $display("FAIL rnd_wdata n=%0d got=%0h exp=%0h", n, s_hwdata, hwdata[down]); end
            checks++; if (m_hready[own] !== s_hready || m_hready[1 - own] !== 1'b0) begin failures++; $display("FAIL rnd_hready n=%0d got=%0b%0b own=%0d", n, m_hready[0], m_hready[1], own); end
            checks++; if (m_hresp[down] !== s_hresp || m_hresp[1 - down] !== 1'b0) begin failures++; $display("FAIL rnd_hresp n=%0d got=%0b%0b down=%0d", n, m_hresp[0], m_hresp[1], down); end
            checks++; if (xfercnt[0] !== cnt[0] || xfercnt[1] !== cnt[1]) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, xfercnt[0], xfercnt[1], cnt[0], cnt[1]); end
            checks++; if (m_hrdata[0] !== s_hrdata || m_hrdata[1] !== s_hrdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%0h exp=%0h", n, m_hrdata[0], s_hrdata); end
            tick();
        end
        rstn = 1;
    endtask

    initial begin
        test_reset();
        test_handover();
        test_back_to_back();
        test_wait_states();
        test_simultaneous();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
